// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-RAM port between the core (m0) and a DMA master (m1).
// Burst-limited round-robin by default; define ARB_FIXED_PRIO_EN for fixed m0 priority.
module data_mem_arbiter #(
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 32,
  parameter int MAX_BURST   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADDR_LENGTH-1:0] m0_addr,
  input  logic [DATA_LENGTH-1:0] m0_wdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADDR_LENGTH-1:0] m1_addr,
  input  logic [DATA_LENGTH-1:0] m1_wdata,
  output logic                   m0_gnt,
  output logic                   m1_gnt,
  output logic                   m0_rvalid,
  output logic                   m1_rvalid,
  output logic [DATA_LENGTH-1:0] m_rdata,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]   contention_cnt
);
  logic sel, xfer, both, rd_pend, rd_tag;
  assign both = m0_req & m1_req;
`ifdef ARB_FIXED_PRIO_EN
  assign sel = ~m0_req;
`else
  localparam int BW = $clog2(MAX_BURST + 1);
  logic owner;
  logic [BW-1:0] burst_cnt;
  assign sel = both ? ((burst_cnt < BW'(MAX_BURST)) ? owner : ~owner) : m1_req;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner     <= 1'b0;
      burst_cnt <= '0;
    end else if (!xfer) begin
      burst_cnt <= '0;
    end else if (m1_gnt == owner) begin
      burst_cnt <= (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
    end else begin
      owner     <= m1_gnt;
      burst_cnt <= BW'(1);
    end
`endif
  // Grants are forced low while reset is held so no strobe escapes mid-reset.
  assign m0_gnt    = rst & m0_req & ~sel;
  assign m1_gnt    = rst & m1_req & sel;
  assign xfer      = m0_gnt | m1_gnt;
  assign mem_addr  = m1_gnt ? m1_addr : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign mem_we    = xfer & (m1_gnt ? m1_we : m0_we);
  assign mem_re    = xfer & ~(m1_gnt ? m1_we : m0_we);
  assign m_rdata   = mem_rdata;
  assign m0_rvalid = rd_pend & ~rd_tag;
  assign m1_rvalid = rd_pend & rd_tag;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_pend        <= 1'b0;
      rd_tag         <= 1'b0;
      contention_cnt <= '0;
    end else begin
      rd_pend <= mem_re;
      if (mem_re) rd_tag <= m1_gnt;
      if (both && contention_cnt != '1) contention_cnt <= contention_cnt + 1'b1;
    end
endmodule
